// File: rtl/serial_add_ctrl.sv
// serial_add_ctrl: bit-serial adder sequencing one full-adder slice LSB-first.
// Ports: start_valid/start_ready, a_in, b_in, cin_in, done_valid/done_ready,
//   sum_out, cout_out, busy, ovf_out (only with `define SERIAL_ADD_OVF_EN).
module serial_add_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_valid,
  output logic             start_ready,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  input  logic             cin_in,
  output logic             done_valid,
  input  logic             done_ready,
  output logic [WIDTH-1:0] sum_out,
  output logic             cout_out,
  output logic             busy
`ifdef SERIAL_ADD_OVF_EN
  ,
  output logic             ovf_out
`endif
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t state;
  state_t state_nxt;

  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] sum_sh;
  logic             carry;
  logic [CW-1:0]    cnt;

  logic s_bit;
  logic c_bit;
  logic last;
  logic accept;

  assign s_bit  = a_sh[0] ^ b_sh[0] ^ carry;
  assign c_bit  = (a_sh[0] & b_sh[0])
                | (carry & (a_sh[0] ^ b_sh[0]));
  assign last   = (cnt == CW'(WIDTH - 1));
  assign accept = start_valid && (state == IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    start_ready = 1'b0;
    busy        = 1'b0;
    done_valid  = 1'b0;
    unique case (state)
      IDLE: begin
        start_ready = 1'b1;
        if (start_valid) state_nxt = RUN;
      end
      RUN: begin
        busy = 1'b1;
        if (last) state_nxt = DONE;
      end
      DONE: begin
        done_valid = 1'b1;
        if (done_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sh     <= '0;
      b_sh     <= '0;
      sum_sh   <= '0;
      carry    <= 1'b0;
      cnt      <= '0;
      sum_out  <= '0;
      cout_out <= 1'b0;
    end else if (accept) begin
      a_sh  <= a_in;
      b_sh  <= b_in;
      carry <= cin_in;
      cnt   <= '0;
    end else if (state == RUN) begin
      a_sh   <= {1'b0, a_sh[WIDTH-1:1]};
      b_sh   <= {1'b0, b_sh[WIDTH-1:1]};
      sum_sh <= {s_bit, sum_sh[WIDTH-1:1]};
      carry  <= c_bit;
      cnt    <= cnt + 1'b1;
      // MSB step: publish the fully shifted sum in the same edge
      if (last) begin
        sum_out  <= {s_bit, sum_sh[WIDTH-1:1]};
        cout_out <= c_bit;
      end
    end
  end

`ifdef SERIAL_ADD_OVF_EN
  // carry still holds the carry into the MSB during the last step
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_out <= 1'b0;
    end else if (!accept && state == RUN && last) begin
      ovf_out <= carry ^ c_bit;
    end
  end
`endif

endmodule
